// File: rtl/pwm_pkg.sv
// Shared types and constants for the multichannel PWM block.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } deb_state_e;

  localparam logic EDGE   = 1'b0;
  localparam logic CENTER = 1'b1;

endpackage

// File: rtl/pb_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM, one-cycle press pulse.
module pb_debounce
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync_ff;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          done;
  deb_state_e    state, state_nxt;

  assign sync = sync_ff[1];
  assign done = (cnt == CW'(DEB_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[0], pb};
  end

  // cnt counts matching samples while waiting; any state change restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                         cnt <= '0;
      else if (state == WAIT_HIGH || state == WAIT_LOW) cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (sync)  state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (!sync) state_nxt = IDLE;
                 else if (done) state_nxt = HELD;
      HELD:      if (!sync) state_nxt = WAIT_LOW;
      WAIT_LOW:  if (sync)  state_nxt = HELD;
                 else if (done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    press = (state == WAIT_HIGH) && (state_nxt == HELD);
  end

endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM with shared edge/center-aligned counter and debounced
// inc/dec buttons adjusting the duty of the selected channel.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter  int N_CH       = 4,
  parameter  int CNT_W      = 8,
  parameter  int STEP       = 16,
  parameter  int DEB_CYCLES = 4,
  localparam int SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_inc,
  input  logic             pb_dec,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic             center_mode,
  output logic [N_CH-1:0]  pwm_out,
  output logic [CNT_W-1:0] duty_sel
);

  localparam logic [CNT_W:0]   MAX_X  = (CNT_W+1)'(2**CNT_W - 1);
  localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);
  localparam logic [CNT_W-1:0] TOP    = CNT_W'(2**CNT_W - 2);

  logic                        inc_p, dec_p;
  logic [CNT_W-1:0]            cnt;
  logic                        dir_down;
  logic                        mode_q, mode_eff;
  logic                        period_start;
  logic [N_CH-1:0]             sel_hit;
  logic [N_CH-1:0]             pwm_next;
  logic [N_CH-1:0][CNT_W-1:0]  duty;

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb_inc),
    .press (inc_p)
  );

  pb_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk   (clk),
    .rst   (rst),
    .pb    (pb_dec),
    .press (dec_p)
  );

  // Mode is sampled only at period start so the counter never jumps.
  assign period_start = (cnt == '0) && !dir_down;
  assign mode_eff     = period_start ? center_mode : mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      dir_down <= 1'b0;
      mode_q   <= EDGE;
    end else begin
      if (period_start) mode_q <= center_mode;
      if (mode_eff == CENTER) begin
        // turning points hold for one extra cycle via the direction flip
        if (!dir_down) begin
          if (cnt == TOP) dir_down <= 1'b1;
          else            cnt      <= cnt + CNT_W'(1);
        end else begin
          if (cnt == '0)  dir_down <= 1'b0;
          else            cnt      <= cnt - CNT_W'(1);
        end
      end else begin
        cnt      <= (cnt == TOP) ? '0 : cnt + CNT_W'(1);
        dir_down <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] duty_r, act_r;
    logic [CNT_W:0]   sum_up, sum_dn;

    assign sel_hit[i] = ({1'b0, ch_sel} == (SEL_W+1)'(i));
    assign sum_up     = {1'b0, duty_r} + STEP_X;
    assign sum_dn     = {1'b0, duty_r} - STEP_X;
    assign duty[i]    = duty_r;
    // the shadow loads at period start, so the new value is already in play
    assign pwm_next[i] = cnt < (period_start ? duty_r : act_r);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_r <= '0;
        act_r  <= '0;
      end else begin
        if (sel_hit[i] && inc_p && !dec_p)
          duty_r <= (sum_up > MAX_X) ? MAX_X[CNT_W-1:0] : sum_up[CNT_W-1:0];
        else if (sel_hit[i] && dec_p && !inc_p)
          duty_r <= sum_dn[CNT_W] ? '0 : sum_dn[CNT_W-1:0];
        if (period_start) act_r <= duty_r;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_out <= '0;
    else     pwm_out <= pwm_next;
  end

  always_comb begin
    duty_sel = '0;
    for (int i = 0; i < N_CH; i++)
      if (sel_hit[i]) duty_sel = duty[i];
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench: phase-based PWM model plus directed button scenarios.
module tb_pwm_multichannel;

  localparam int N_CH = 4, CNT_W = 8, STEP = 16, DEB = 4, MAX = 255, SEL_W = 2;
  localparam int LAT = 3 + DEB;  // raw edge to committed duty: 2 sync + entry + DEB samples

  logic             clk = 0, rst = 0, pb_inc = 0, pb_dec = 0, center_mode = 0;
  logic [SEL_W-1:0] ch_sel = '0;
  logic [N_CH-1:0]  pwm_out;
  logic [CNT_W-1:0] duty_sel;

  pwm_multichannel #(.N_CH(N_CH), .CNT_W(CNT_W), .STEP(STEP), .DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_inc      (pb_inc),
    .pb_dec      (pb_dec),
    .ch_sel      (ch_sel),
    .center_mode (center_mode),
    .pwm_out     (pwm_out),
    .duty_sel    (duty_sel)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: position within the period, converted to a counter value by shape.
  int              m_duty[N_CH];
  int              m_active[N_CH];
  int              m_phase;
  bit              m_mode;
  logic [N_CH-1:0] m_out;

  function automatic int cval(input int ph, input bit md);
    if (md && ph >= MAX) return 2*MAX - 1 - ph;
    return ph;
  endfunction

  function automatic logic [N_CH-1:0] exp_out(input int ph, input bit md, input int act[N_CH]);
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = (cval(ph, md) < act[i]);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_mode   <= 1'b0;
      m_out    <= '0;
      m_active <= '{default: 0};
    end else if (m_phase == 0) begin
      m_mode   <= center_mode;
      m_active <= m_duty;
      m_out    <= exp_out(0, center_mode, m_duty);
      m_phase  <= 1;
    end else begin
      m_out    <= exp_out(m_phase, m_mode, m_active);
      m_phase  <= (m_phase + 1) % (m_mode ? 2*MAX : MAX);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("pwm_out", int'(pwm_out), int'(m_out));
      check("duty_sel", int'(duty_sel), (ch_sel < N_CH) ? m_duty[ch_sel] : 0);
    end
  end

  task automatic apply(input bit inc, input bit dec);
    int c;
    c = ch_sel;
    if (!(inc && dec) && c < N_CH) begin
      if (inc) m_duty[c] = (m_duty[c] + STEP > MAX) ? MAX : m_duty[c] + STEP;
      else     m_duty[c] = (m_duty[c] - STEP < 0)   ? 0   : m_duty[c] - STEP;
    end
  endtask

  // Caller is aligned #1 after a rising edge; buttons held for 'hi' edges.
  task automatic press(input bit inc, input bit dec, input int hi);
    pb_inc = inc;
    pb_dec = dec;
    for (int e = 1; e <= hi + 12; e++) begin
      @(posedge clk); #1;
      if (e == hi) begin pb_inc = 0; pb_dec = 0; end
      if (e == LAT && hi > DEB) apply(inc, dec);
    end
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 4*MAX && m_phase != ph; i++) begin
      @(posedge clk); #1;
    end
    check("wait_phase", m_phase, ph);
  endtask

  task automatic count_high(input int n, output int hc[N_CH]);
    hc = '{default: 0};
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) hc[i] += int'(pwm_out[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < N_CH; i++) m_duty[i] = 0;
    #1;
    check("rst_async_pwm", int'(pwm_out), 0);
    check("rst_async_duty", int'(duty_sel), 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    int hc[N_CH];
    int bad;
    #1;
    do_reset();

    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (pwm_out != 0 || duty_sel != 0) bad++;
    end
    check("reset_idle_600", bad, 0);
    @(posedge clk); #1;

    // bounce rejected; a long hold yields exactly one step
    ch_sel = 0;
    press(1, 0, 2);
    check("bounce_no_change", int'(duty_sel), 0);
    press(1, 0, 40);
    check("held_single_step", int'(duty_sel), 16);
    check("model_duty0", m_duty[0], 16);
    wait_phase(5);
    count_high(MAX, hc);
    check("ch0_high_16", hc[0], 16);
    check("ch1_idle", hc[1], 0);
    check("ch2_idle", hc[2], 0);
    check("ch3_idle", hc[3], 0);

    ch_sel = 2;
    repeat (17) press(1, 0, 10);
    check("ch2_saturate", int'(duty_sel), 255);
    wait_phase(5);
    count_high(MAX, hc);
    check("ch2_const_high", hc[2], 255);

    ch_sel = 3;
    press(0, 1, 10);
    check("ch3_floor", int'(duty_sel), 0);
    ch_sel = 0;
    press(1, 1, 10);
    check("inc_dec_cancel", int'(duty_sel), 16);

    // mid-period change only takes effect from the next period
    wait_phase(100);
    press(1, 0, 10);
    check("mid_inc_duty", int'(duty_sel), 32);
    wait_phase(5);
    count_high(MAX, hc);
    check("ch0_high_32", hc[0], 32);

    center_mode = 1;
    ch_sel = 1;
    repeat (4) press(1, 0, 10);
    check("ch1_duty_64", int'(duty_sel), 64);
    wait_phase(0);
    wait_phase(5);
    check("model_center", int'(m_mode), 1);
    count_high(2*MAX, hc);
    check("ch1_center_128", hc[1], 128);
    check("ch0_center_64", hc[0], 64);
    check("ch2_center_const", hc[2], 510);
    wait_phase(2);
    check("center_high_near_0", int'(pwm_out[1]), 1);
    wait_phase(256);
    check("center_low_near_top", int'(pwm_out[1]), 0);

    // reset mid-period with a button held: it must be re-debounced once
    wait_phase(300);
    pb_inc = 1;
    do_reset();
    press(1, 0, 10);
    check("held_through_reset", int'(duty_sel), 16);
    repeat (600) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 Parameter N_CH, 4, number of independent PWM channels (1..16).
REQ-002 Parameter CNT_W, 8, duty/counter width; MAX = 2**CNT_W-1.
REQ-003 Parameter STEP, 16, duty increment/decrement per accepted button press (1..MAX).
REQ-004 Parameter DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a button level change (>=1).
REQ-005 Port clk  input  1  single clock; all state rising-edge triggered.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port pb_inc  input  1  raw increment push button, asynchronous to clk, bouncing.
REQ-008 Port pb_dec  input  1  raw decrement push button, asynchronous to clk, bouncing.
REQ-009 Port ch_sel  input  max(1,$clog2(N_CH))  channel targeted by button presses; values >= N_CH ignore presses.
REQ-010 Port center_mode  input  1  0 = edge-aligned, 1 = center-aligned counting.
REQ-011 Port pwm_out  output  N_CH  one PWM output per channel, registered.
REQ-012 Port duty_sel  output  CNT_W  committed duty register of channel ch_sel (0 if ch_sel >= N_CH).

Function
REQ-013 Each button passes a 2-flop synchronizer, then a debounce FSM: IDLE -> WAIT_HIGH on sync=1; WAIT_HIGH -> HELD after DEB_CYCLES consecutive 1s, back to IDLE on any 0; HELD -> WAIT_LOW on sync=0; WAIT_LOW -> IDLE after DEB_CYCLES consecutive 0s, back to HELD on any 1.
REQ-014 Transition WAIT_HIGH -> HELD emits exactly one single-cycle press pulse; holding a button never repeats.
REQ-015 Inc pulse: duty[ch_sel] = min(duty+STEP, MAX); dec pulse: duty[ch_sel] = max(duty-STEP, 0); computed at CNT_W+1 bits, no wrap.
REQ-016 Inc and dec pulses in the same cycle: no duty change.
REQ-017 duty register updates on the clock edge after the pulse cycle; only the selected channel changes.
REQ-018 Each channel holds a shadow (active) duty copied from duty at period start only (counter==0, counting up); mid-period changes never alter the current period.
REQ-019 Edge mode: shared counter 0..MAX-1 then wraps to 0; period MAX cycles.
REQ-020 Center mode: counter counts up 0..MAX-1, holds MAX-1 for one extra cycle turning down, counts down to 0, holds 0 one extra cycle turning up; period 2*MAX cycles.
REQ-021 pwm_out[i] registered = (counter < active_duty[i]); duty 0 -> constant 0, duty MAX -> constant 1; high time = duty (edge) or 2*duty (center) cycles per period.
REQ-022 center_mode change takes effect only at next period start (counter==0, up); counter never jumps.

Reset
REQ-023 rst=1 asynchronously forces: all duty and active duty = 0, counter = 0, direction = up, debounce FSMs = IDLE, synchronizers = 0, latched mode = edge, pwm_out = 0, duty_sel = 0.
REQ-024 Reset mid-period or mid-press discards all in-flight state; a button still held after release of rst must be re-debounced (one press).

Structure
REQ-025 Shared package pwm_pkg holds the debounce state enum (IDLE, WAIT_HIGH, HELD, WAIT_LOW) and mode constants (EDGE=0, CENTER=1).
REQ-026 Sub-module pb_debounce (synchronizer + FSM + pulse, parameter DEB_CYCLES) instantiated once per button.

Verification (N_CH=4, CNT_W=8, STEP=16, DEB_CYCLES=4, MAX=255)
REQ-027 Assert rst 3 cycles, release -> pwm_out=4'b0000, duty_sel=0 for 600 cycles.
REQ-028 ch_sel=0, pb_inc high 2 cycles (bounce) -> no change; pb_inc high 10 cycles -> duty_sel=16 once; next period pwm_out[0] high exactly 16 of 255 cycles, other channels 0.
REQ-029 17 full presses on ch 2 -> duty saturates at 255, pwm_out[2] constant 1; pb_dec on ch 3 at 0 -> stays 0; pb_inc and pb_dec debounced together -> duty unchanged.
REQ-030 center_mode=1, ch1 duty 64 -> after next period start, pwm_out[1] high 128 of 510 cycles, centered on counter value 0.
REQ-031 Inc press mid-period -> current period unchanged, new width from next counter==0; rst pulse mid-period -> all outputs 0 immediately (asynchronous).
